// File: rtl/cpu_mem_io_if.sv
// rtl/cpu_mem_io_if.sv - CPU bus and ROM loader stream signals shared by cpu_mem_io and its driver
interface cpu_mem_io_if;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_write;
  logic [7:0] cpu_rdata;
  logic       cpu_reset;
  logic       prog_start;
  logic       prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready;

  modport master (
    output cpu_addr, cpu_wdata, cpu_write, prog_start, prog_valid, prog_data,
    input  cpu_rdata, cpu_reset, prog_ready
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_write, prog_start, prog_valid, prog_data,
    output cpu_rdata, cpu_reset, prog_ready
  );
endinterface

// File: rtl/cpu_mem_io.sv
// rtl/cpu_mem_io.sv - RAM, IO page (ports, down-timer, status) and streamed program ROM on the 8-bit CPU bus
module cpu_mem_io #(
  parameter int RAM_AW   = 6,
  parameter int PRESCALE = 16
) (
  input  logic       clk,
  input  logic       reset,
  cpu_mem_io_if.slave bus,
  input  logic [7:0] port_in,
  output logic [7:0] port_out,
  output logic       irq
);
  localparam int RAM_SIZE = 1 << RAM_AW;
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} load_state_t;

  logic [7:0]    ram [RAM_SIZE];
  logic [7:0]    rom [128];
  logic [7:0]    reload_q, count_q, sync1_q, sync2_q;
  logic          en_q, auto_q, expired_q, loaded_q;
  logic [PW-1:0] presc_q;
  logic [6:0]    idx_q;
  load_state_t   state_q, state_d;

  logic in_ram, wr, tick, accept;

  assign in_ram = ({24'd0, bus.cpu_addr} < RAM_SIZE);
  assign wr     = bus.cpu_write && !bus.cpu_reset;
  assign tick   = en_q && (presc_q == PW'(PRESCALE - 1));
  // prog_start wins over a byte offered in the same cycle: the image restarts from idx 0
  assign accept = bus.prog_ready && bus.prog_valid && !bus.prog_start;

  assign bus.prog_ready = (state_q == LOAD);
  assign irq            = expired_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      loaded_q      <= 1'b0;
      bus.cpu_reset <= 1'b1;
    end else begin
      state_q       <= state_d;
      bus.cpu_reset <= (state_d != DONE);
      if (state_d == LOAD && (state_q != LOAD || bus.prog_start)) begin
        idx_q    <= '0;
        loaded_q <= 1'b0;
      end else if (accept) begin
        idx_q <= idx_q + 7'd1;
      end
      if (state_d == DONE && state_q != DONE)
        loaded_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.prog_start) state_d = LOAD;
      LOAD:    if (accept && idx_q == 7'd127) state_d = DONE;
      DONE:    if (bus.prog_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // Arrays have no reset so a mid-load reset keeps the bytes already written
  always_ff @(posedge clk) begin
    if (accept)
      rom[idx_q] <= bus.prog_data;
    if (wr && in_ram)
      ram[bus.cpu_addr[RAM_AW-1:0]] <= bus.cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= port_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port_out  <= '0;
      reload_q  <= '0;
      count_q   <= '0;
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      expired_q <= 1'b0;
      presc_q   <= '0;
    end else begin
      if (en_q)
        presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (count_q != 8'd0)
          count_q <= count_q - 8'd1;
        else if (auto_q)
          count_q <= reload_q;
        else
          en_q <= 1'b0;
      end
      if (wr) begin
        case (bus.cpu_addr)
          8'h40: port_out <= bus.cpu_wdata;
          8'h42: reload_q <= bus.cpu_wdata;
          8'h44: begin
            en_q   <= bus.cpu_wdata[0];
            auto_q <= bus.cpu_wdata[1];
            if (bus.cpu_wdata[0] && !en_q) begin
              count_q <= reload_q;
              presc_q <= '0;
            end
          end
          8'h45: if (bus.cpu_wdata[0]) expired_q <= 1'b0;
          default: ;
        endcase
      end
      // Expiry is applied last so it beats a simultaneous write-one-to-clear
      if (tick && count_q == 8'd0)
        expired_q <= 1'b1;
    end
  end

  always_comb begin
    bus.cpu_rdata = 8'h00;
    if (in_ram)
      bus.cpu_rdata = ram[bus.cpu_addr[RAM_AW-1:0]];
    else if (bus.cpu_addr[7])
      bus.cpu_rdata = rom[bus.cpu_addr[6:0]];
    else begin
      case (bus.cpu_addr)
        8'h40:   bus.cpu_rdata = port_out;
        8'h41:   bus.cpu_rdata = sync2_q;
        8'h42:   bus.cpu_rdata = reload_q;
        8'h43:   bus.cpu_rdata = count_q;
        8'h44:   bus.cpu_rdata = {6'd0, auto_q, en_q};
        8'h45:   bus.cpu_rdata = {6'd0, loaded_q, expired_q};
        default: bus.cpu_rdata = 8'h00;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_mem_io.sv
// tb/tb_cpu_mem_io.sv - directed self-checking bench for cpu_mem_io
module tb_cpu_mem_io;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_in;
  logic [7:0] port_out;
  logic       irq;
  int         errors = 0;
  int         checks = 0;
  int         falls = 0;

  cpu_mem_io_if bus();

  cpu_mem_io #(.RAM_AW(6), .PRESCALE(16)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .port_in(port_in), .port_out(port_out), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(negedge bus.cpu_reset) falls++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] a, input string tag, input logic [7:0] exp);
    bus.cpu_addr = a;
    #1;
    chk(tag, bus.cpu_rdata, exp);
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_write = 1'b1;
    tick();
    bus.cpu_write = 1'b0;
  endtask

  task automatic start_load();
    bus.prog_start = 1'b1;
    tick();
    bus.prog_start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [7:0] pat, input bit gaps);
    int   acc = 0;
    int   budget = 0;
    logic rdy;
    while (acc < n && budget < 4000) begin
      bus.prog_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.prog_data  = 8'(acc) ^ pat;
      rdy = bus.prog_ready;
      tick();
      if (bus.prog_valid && rdy) acc++;
      budget++;
    end
    bus.prog_valid = 1'b0;
    chk("feed_complete", 8'(acc), 8'(n));
  endtask

  initial begin
    reset = 1'b1;
    port_in = 8'h00;
    bus.cpu_addr = 8'h00; bus.cpu_wdata = 8'h00; bus.cpu_write = 1'b0;
    bus.prog_start = 1'b0; bus.prog_valid = 1'b0; bus.prog_data = 8'h00;
    repeat (2) tick();
    chk("rst_cpu_reset", 8'(bus.cpu_reset), 8'd1);
    chk("rst_prog_ready", 8'(bus.prog_ready), 8'd0);
    chk("rst_port_out", port_out, 8'h00);
    chk("rst_irq", 8'(irq), 8'd0);
    rd(8'h45, "rst_status", 8'h00);
    rd(8'h43, "rst_count", 8'h00);
    reset = 1'b0;
    tick();

    // 1: full image load with random gaps
    start_load();
    chk("load_ready", 8'(bus.prog_ready), 8'd1);
    chk("load_cpu_reset_hi", 8'(bus.cpu_reset), 8'd1);
    feed(128, 8'h00, 1'b1);
    chk("done_cpu_reset_lo", 8'(bus.cpu_reset), 8'd0);
    chk("done_ready_lo", 8'(bus.prog_ready), 8'd0);
    rd(8'h45, "done_status", 8'h02);
    for (int i = 0; i < 128; i++) rd(8'(8'h80 + i), "rom_image", 8'(i));
    chk("cpu_reset_falls", 8'(falls), 8'd1);

    // 2: port, ROM write protection, RAM, unmapped
    cpu_wr(8'h40, 8'h5A);
    chk("port_out_wr", port_out, 8'h5A);
    rd(8'h40, "port_out_rd", 8'h5A);
    cpu_wr(8'h80, 8'hFF);
    rd(8'h80, "rom_ro", 8'h00);
    cpu_wr(8'h10, 8'h33);
    rd(8'h10, "ram_10", 8'h33);
    cpu_wr(8'h3F, 8'hC3);
    rd(8'h3F, "ram_top", 8'hC3);
    rd(8'h60, "unmapped_60", 8'h00);
    cpu_wr(8'h46, 8'h99);
    rd(8'h46, "unmapped_46", 8'h00);

    // 3: autoreload timer, RELOAD=3 -> 64 cycles per expiry
    cpu_wr(8'h42, 8'h03);
    cpu_wr(8'h44, 8'h03);
    repeat (63) tick();
    chk("auto_irq_63", 8'(irq), 8'd0);
    tick();
    chk("auto_irq_64", 8'(irq), 8'd1);
    rd(8'h43, "auto_reload_count", 8'h03);
    cpu_wr(8'h45, 8'h01);
    chk("w1c_clear", 8'(irq), 8'd0);
    repeat (62) tick();
    chk("auto2_irq_127", 8'(irq), 8'd0);
    tick();
    chk("auto2_irq_128", 8'(irq), 8'd1);
    cpu_wr(8'h45, 8'h00);
    chk("w0_no_effect", 8'(irq), 8'd1);
    cpu_wr(8'h44, 8'h00);
    cpu_wr(8'h45, 8'h01);
    chk("w1c_clear2", 8'(irq), 8'd0);

    // 4: one-shot with W1C landing on the expiry edge
    cpu_wr(8'h42, 8'h00);
    cpu_wr(8'h44, 8'h01);
    repeat (15) tick();
    chk("oneshot_irq_15", 8'(irq), 8'd0);
    cpu_wr(8'h45, 8'h01);
    chk("oneshot_set_wins", 8'(irq), 8'd1);
    rd(8'h44, "oneshot_en_clr", 8'h00);
    rd(8'h45, "oneshot_status", 8'h03);
    repeat (20) tick();
    chk("oneshot_irq_hold", 8'(irq), 8'd1);
    cpu_wr(8'h45, 8'h01);
    chk("oneshot_clear", 8'(irq), 8'd0);

    // 5: input synchronizer latency
    bus.cpu_addr = 8'h41;
    port_in = 8'hA5;
    tick();
    chk("port_in_1cyc", bus.cpu_rdata, 8'h00);
    tick();
    chk("port_in_2cyc", bus.cpu_rdata, 8'hA5);

    // 6: reset mid-load, then a clean reload
    start_load();
    chk("reload_cpu_reset", 8'(bus.cpu_reset), 8'd1);
    rd(8'h45, "reload_loaded_clr", 8'h00);
    cpu_wr(8'h40, 8'h77);
    chk("wr_blocked_in_reset", port_out, 8'h5A);
    feed(40, 8'hFF, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("mid_rst_ready", 8'(bus.prog_ready), 8'd0);
    chk("mid_rst_cpu_reset", 8'(bus.cpu_reset), 8'd1);
    chk("mid_rst_port_out", port_out, 8'h00);
    rd(8'h45, "mid_rst_status", 8'h00);
    rd(8'h85, "mid_rst_rom_kept", 8'hFA);
    rd(8'hB2, "mid_rst_rom_old", 8'h32);
    repeat (3) tick();
    chk("idle_stays", 8'(bus.prog_ready), 8'd0);
    start_load();
    feed(128, 8'h55, 1'b1);
    chk("reload_cpu_reset_lo", 8'(bus.cpu_reset), 8'd0);
    rd(8'h45, "reload_status", 8'h02);
    rd(8'h80, "reload_rom_00", 8'h55);
    rd(8'hA8, "reload_rom_28", 8'h7D);
    rd(8'hFF, "reload_rom_7f", 8'h2A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
